// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle signed multiply/divide unit for the MIPS datapath. It takes the
// rs/rt operands and runs a 32-iteration radix-2 Booth multiply or a
// 32-iteration restoring divide. The result is held in HI/LO until the next
// completion.
//
// Ports:
//   Clk         in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   A           in  32  rs operand (multiplicand / dividend)
//   B           in  32  rt operand (multiplier / divisor)
//   mult_start  in   1  request signed MULT (sampled only when idle)
//   div_start   in   1  request signed DIV  (sampled only when idle)
//   busy        out  1  operation in progress (registered)
//   done        out  1  one-cycle completion pulse; HI/LO valid from this cycle
//   div_zero    out  1  one-cycle pulse with done on divide-by-zero / rejected DIV
//   HI          out 32  MULT product[63:32] / DIV remainder
//   LO          out 32  MULT product[31:0]  / DIV quotient
//
// Build option:
//   MULT_DIV_DIVIDER_EN  when defined, the divider datapath and DIV state are
//                        compiled in. When undefined, a DIV request takes the
//                        same one-cycle path as a divide by zero: it pulses
//                        done and div_zero and leaves HI/LO unchanged.
// -----------------------------------------------------------------------------
module mult_div_unit (
   input  logic        Clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        mult_start,
   input  logic        div_start,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

`ifdef MULT_DIV_DIVIDER_EN
   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;
`else
   // S_REJ is the single cycle spent answering an unsupported DIV request.
   typedef enum logic [1:0] {S_IDLE, S_MULT, S_REJ} state_t;
`endif

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // Shared iteration registers:
   //   MULT: acc = Booth accumulator, qr = multiplier, m = sign-extended multiplicand
   //   DIV:  acc = partial remainder, qr = dividend/quotient, m = divisor magnitude
   logic [32:0] acc_q, acc_d;
   logic [31:0] qr_q, qr_d;
   logic        qm1_q, qm1_d;
   logic [32:0] m_q, m_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dz_q, dz_d;

   // ---------------------------------------------------------------------------
   // Booth step. The accumulator is 33 bits wide, so subtracting a multiplicand
   // of -2^31 cannot overflow. {acc, qr, qm1} shifts right arithmetically.
   // ---------------------------------------------------------------------------
   logic [32:0] booth_sum;
   logic [32:0] booth_acc;
   logic [31:0] booth_qr;

   always_comb begin
      booth_sum = acc_q;
      case ({qr_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_q;
         2'b10:   booth_sum = acc_q - m_q;
         default: booth_sum = acc_q;
      endcase
   end

   assign booth_acc = {booth_sum[32], booth_sum[32:1]};
   assign booth_qr  = {booth_sum[0], qr_q[31:1]};

`ifdef MULT_DIV_DIVIDER_EN
   // ---------------------------------------------------------------------------
   // Restoring divide step on magnitudes. Because the remainder stays below the
   // divisor (at most 2^31), the shifted remainder fits in 33 bits and bit 32 of
   // the trial result is a valid sign.
   // ---------------------------------------------------------------------------
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic        dzp_q, dzp_d;
   logic [31:0] a_mag, b_mag;
   logic [32:0] div_shift, div_trial, div_acc;
   logic [31:0] div_qr, quot_fix, rem_fix;

   // The magnitude of -2^31 is 0x80000000, which is still correct as unsigned.
   assign a_mag     = A[31] ? (32'd0 - A) : A;
   assign b_mag     = B[31] ? (32'd0 - B) : B;
   assign div_shift = {acc_q[31:0], qr_q[31]};
   assign div_trial = div_shift - m_q;
   assign div_acc   = div_trial[32] ? div_shift : div_trial;
   assign div_qr    = {qr_q[30:0], ~div_trial[32]};
   // The quotient truncates toward zero; the remainder follows the dividend's sign.
   assign quot_fix  = neg_q_q ? (32'd0 - div_qr) : div_qr;
   assign rem_fix   = neg_r_q ? (32'd0 - div_acc[31:0]) : div_acc[31:0];
`endif

   // ---------------------------------------------------------------------------
   // Next-state / datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case; any path that
      // left one unassigned would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      qr_d    = qr_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      dzp_d   = dzp_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (mult_start) begin
               // MULT has priority. A coincident div_start is dropped.
               state_d = S_MULT;
               cnt_d   = 6'd0;
               acc_d   = 33'd0;
               qr_d    = B;
               qm1_d   = 1'b0;
               m_d     = {A[31], A};
            end else if (div_start) begin
`ifdef MULT_DIV_DIVIDER_EN
               state_d = S_DIV;
               cnt_d   = 6'd0;
               acc_d   = 33'd0;
               qr_d    = a_mag;
               qm1_d   = 1'b0;
               m_d     = {1'b0, b_mag};
               neg_q_d = A[31] ^ B[31];
               neg_r_d = A[31];
               dzp_d   = (B == 32'd0);
`else
               state_d = S_REJ;
`endif
            end
         end

         S_MULT: begin
            acc_d = booth_acc;
            qr_d  = booth_qr;
            qm1_d = qr_q[0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_IDLE;
               cnt_d   = 6'd0;
               hi_d    = booth_acc[31:0];
               lo_d    = booth_qr;
               done_d  = 1'b1;
            end
         end

`ifdef MULT_DIV_DIVIDER_EN
         S_DIV: begin
            if (dzp_q) begin
               // A zero divisor skips the iterations and leaves HI/LO untouched.
               state_d = S_IDLE;
               dzp_d   = 1'b0;
               done_d  = 1'b1;
               dz_d    = 1'b1;
            end else begin
               acc_d = div_acc;
               qr_d  = div_qr;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = S_IDLE;
                  cnt_d   = 6'd0;
                  hi_d    = rem_fix;
                  lo_d    = quot_fix;
                  done_d  = 1'b1;
               end
            end
         end
`else
         S_REJ: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
         end
`endif

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 33'd0;
         qr_q    <= 32'd0;
         qm1_q   <= 1'b0;
         m_q     <= 33'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dzp_q   <= 1'b0;
`endif
      end else begin
         // NOTE: registers take non-blocking assignments so every flop samples
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         qr_q    <= qr_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
`ifdef MULT_DIV_DIVIDER_EN
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         dzp_q   <= dzp_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed, self-checking bench for mult_div_unit. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge, away from the
// active rising edge. When MULT_DIV_DIVIDER_EN is undefined, every DIV request
// is expected to return done and div_zero after one edge and leave HI/LO as
// they were.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        Clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic        mult_start, div_start;
   logic        busy, done, div_zero;
   logic [31:0] HI, LO;

   int n_vec  = 0;
   int n_miss = 0;

   // The bench's own record of what HI/LO should currently hold.
   logic [31:0] hi_m, lo_m;

`ifdef MULT_DIV_DIVIDER_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   mult_div_unit dut (
      .Clk        (Clk),
      .reset      (reset),
      .A          (A),
      .B          (B),
      .mult_start (mult_start),
      .div_start  (div_start),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .HI         (HI),
      .LO         (LO)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge. Drives the start request across the next rising
   // edge (E0), then scrambles the operands to show they were captured at E0.
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      A          = a;
      B          = b;
      mult_start = m;
      div_start  = d;
      @(negedge Clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      A          = $urandom;
      B          = $urandom;
   endtask

   // Entered in the cycle after E0. lat counts the rising edges until done is
   // seen; busy_cnt counts the busy cycles before that. When inject_at >= 0, a
   // div_start pulse is driven across the edge following cycle inject_at.
   task automatic wait_done(input int inject_at, output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         if (lat == inject_at) begin
            div_start = 1'b1;
            A         = 32'd5;
            B         = 32'd0;
         end
         @(negedge Clk);
         div_start = 1'b0;
         lat++;
      end
   endtask

   // Runs one full operation and checks latency, busy length, and the
   // done-cycle outputs. exp is {HI,LO} for an accepted operation.
   task automatic do_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit skip_tail);
      int          lat, bc, exp_lat;
      logic        exp_dz;
      logic [63:0] exp_hl;
      exp_dz  = d && !m && (b == 32'd0 || !DIV_EN);
      exp_hl  = exp_dz ? {hi_m, lo_m} : exp;
      exp_lat = exp_dz ? 1 : 32;
      issue(m, d, a, b);
      wait_done(-1, lat, bc);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
      check({tag, "_hilo"}, {HI, LO}, exp_hl);
      check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      {hi_m, lo_m} = exp_hl;
      if (!skip_tail) begin
         @(negedge Clk);
         check({tag, "_done_pulse"}, {62'd0, done, div_zero}, 64'd0);
      end
   endtask

   initial begin
      int lat, bc, extra;

      reset      = 1'b1;
      A          = 32'd0;
      B          = 32'd0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      hi_m       = 32'd0;
      lo_m       = 32'd0;
      repeat (2) @(negedge Clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div_zero", 64'(div_zero), 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      reset = 1'b0;
      @(negedge Clk);

      // Multiply vectors (hand-computed signed products)
      do_op("mul_7_m3",   1'b1, 1'b0, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      do_op("mul_maxpos", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
      do_op("mul_minneg", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
      do_op("mul_min_1",  1'b1, 1'b0, 32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000, 1'b0);

      // Divide vectors (quotient in LO, remainder in HI)
      do_op("div_m7_2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
      do_op("div_ovf",    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
      do_op("div_100_7",  1'b0, 1'b1, 32'd100,      32'd7,        64'h0000_0002_0000_000E, 1'b0);
      do_op("div_7_m2",   1'b0, 1'b1, 32'd7,        32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);

      // Preload HI/LO, then divide by zero: HI/LO must be held
      do_op("pre_dz",     1'b1, 1'b0, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      do_op("div_by_0",   1'b0, 1'b1, 32'd5,        32'd0,        64'd0,                  1'b0);

      // Both starts together: MULT wins
      do_op("both_start", 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);

      // div_start pulsed at cycle 10 of a MULT is ignored; exactly one done follows
      issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_done(10, lat, bc);
      check("ign_latency", 64'(lat), 64'd32);
      check("ign_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
      check("ign_div_zero", 64'(div_zero), 64'd0);
      {hi_m, lo_m} = {HI, LO} === 64'hFFFF_FFFF_FFFF_FFEB ? {HI, LO} : 64'hFFFF_FFFF_FFFF_FFEB;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (done || busy) extra++;
      end
      check("ign_no_extra_activity", 64'(extra), 64'd0);

      // Back-to-back: second start is issued during the done cycle
      do_op("b2b_first",  1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
      do_op("b2b_second", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);

      // Reset at cycle 10 of a MULT aborts it
      issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      repeat (10) @(negedge Clk);
      reset = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hilo", {HI, LO}, 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(negedge Clk);
      reset = 1'b0;
      hi_m  = 32'd0;
      lo_m  = 32'd0;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (done || busy) extra++;
      end
      check("abort_no_done", 64'(extra), 64'd0);
      check("abort_hilo_after", {HI, LO}, 64'd0);
      do_op("after_reset", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
